// File: rtl/iram_loader_pkg.sv
// Shared definitions for the instruction-RAM boot loader: FSM state encoding,
// byte-stream framing constants and the length-validity helper.
package iram_loader_pkg;

   typedef enum logic [3:0] {
      IDLE,
      LEN_HI,
      LEN_LO,
      DATA_HI,
      DATA_LO,
      WRITE,
      CSUM,
      DONE,
      ERR
   } state_t;

   localparam int HDR_LEN  = 2;
   localparam int CSUM_LEN = 1;

   // A word count is usable only if it is non-zero and fits the address space
   function automatic logic len_ok(input logic [15:0] n, input int addr_w);
      return (n != 16'd0) && (32'(n) <= (32'd1 << addr_w));
   endfunction

endpackage

// File: rtl/iram_loader.sv
// Instruction-RAM loader: receives a length-prefixed, checksummed byte stream
// and writes it as big-endian words into instruction memory starting at 0.
module iram_loader
   import iram_loader_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 16
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              start,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              rx_ready,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [ADDR_W:0]   words_loaded
);

   state_t            state;
   state_t            state_next;
   logic [15:0]       len;
   logic [7:0]        data_hi;
   logic [7:0]        csum;
   logic [ADDR_W-1:0] addr;
   logic              accept;
   logic              last_word;

   assign accept    = rx_valid && rx_ready;
   assign last_word = (32'(words_loaded) + 32'd1) == 32'(len);
   assign wr_addr   = addr;

   always_comb begin
      state_next = state;
      unique case (state)
         IDLE, DONE, ERR: if (start) state_next = LEN_HI;
         LEN_HI:  if (accept) state_next = LEN_LO;
         LEN_LO:  if (accept) state_next = len_ok({len[15:8], rx_data}, ADDR_W) ? DATA_HI : ERR;
         DATA_HI: if (accept) state_next = DATA_LO;
         DATA_LO: if (accept) state_next = WRITE;
         WRITE:   state_next = last_word ? CSUM : DATA_HI;
         CSUM:    if (accept) state_next = (rx_data == csum) ? DONE : ERR;
         default: state_next = IDLE;
      endcase
   end

   // Outputs are registered from the next state so they line up with it
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state        <= IDLE;
         rx_ready     <= 1'b0;
         busy         <= 1'b0;
         wr_en        <= 1'b0;
         done         <= 1'b0;
         error        <= 1'b0;
         wr_data      <= '0;
         len          <= '0;
         data_hi      <= '0;
         csum         <= '0;
         addr         <= '0;
         words_loaded <= '0;
      end else begin
         state    <= state_next;
         rx_ready <= state_next inside {LEN_HI, LEN_LO, DATA_HI, DATA_LO, CSUM};
         busy     <= !(state_next inside {IDLE, DONE, ERR});
         wr_en    <= (state_next == WRITE);
         done     <= (state_next == DONE);
         error    <= (state_next == ERR);

         unique case (state)
            IDLE, DONE, ERR: begin
               if (start) begin
                  addr         <= '0;
                  csum         <= '0;
                  words_loaded <= '0;
               end
            end
            LEN_HI: begin
               if (accept) begin
                  len[15:8] <= rx_data;
                  csum      <= csum + rx_data;
               end
            end
            LEN_LO: begin
               if (accept) begin
                  len[7:0] <= rx_data;
                  csum     <= csum + rx_data;
               end
            end
            DATA_HI: begin
               if (accept) begin
                  data_hi <= rx_data;
                  csum    <= csum + rx_data;
               end
            end
            DATA_LO: begin
               if (accept) begin
                  wr_data <= DATA_W'({data_hi, rx_data});
                  csum    <= csum + rx_data;
               end
            end
            WRITE: begin
               addr         <= addr + ADDR_W'(1);
               words_loaded <= words_loaded + (ADDR_W + 1)'(1);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_iram_loader.sv
// Scoreboard bench for iram_loader: stimulus pushes expected writes, a monitor
// pops and compares every wr_en strobe; end-of-load flags are checked directly.
module tb_iram_loader;

   localparam int ADDR_W = 8;
   localparam int DATA_W = 16;

   logic              clock;
   logic              reset_n;
   logic              start;
   logic [7:0]        rx_data;
   logic              rx_valid;
   logic              rx_ready;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              busy;
   logic              done;
   logic              error;
   logic [ADDR_W:0]   words_loaded;

   int checks   = 0;
   int failures = 0;
   logic [ADDR_W+DATA_W-1:0] exp_q[$];

   iram_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clock(clock),
      .reset_n(reset_n),
      .start(start),
      .rx_data(rx_data),
      .rx_valid(rx_valid),
      .rx_ready(rx_ready),
      .wr_en(wr_en),
      .wr_addr(wr_addr),
      .wr_data(wr_data),
      .busy(busy),
      .done(done),
      .error(error),
      .words_loaded(words_loaded)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic expect_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      exp_q.push_back({a, d});
   endtask

   // Monitor: every write strobe must match the head of the scoreboard
   always @(negedge clock) begin
      if (reset_n && wr_en) begin
         check("ready_low_in_write", 32'(rx_ready), 32'd0);
         if (exp_q.size() == 0) begin
            check("unexpected_write", {8'd0, wr_addr, wr_data}, 32'hFFFF_FFFF);
         end else begin
            logic [ADDR_W+DATA_W-1:0] e;
            e = exp_q.pop_front();
            check("write_addr", 32'(wr_addr), 32'(e[ADDR_W+DATA_W-1:DATA_W]));
            check("write_data", 32'(wr_data), 32'(e[DATA_W-1:0]));
         end
      end
   end

   // Called at a falling edge; returns at the falling edge after the transfer
   task automatic send_byte(input logic [7:0] b, input int gap);
      int waits;
      waits = 0;
      rx_valid = 1'b0;
      repeat (gap) @(negedge clock);
      rx_valid = 1'b1;
      rx_data  = b;
      while (!rx_ready && waits < 100) begin
         @(negedge clock);
         waits++;
      end
      if (!rx_ready) begin
         check("send_timeout", 32'd0, 32'd1);
      end else begin
         @(negedge clock);
      end
      rx_valid = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
   endtask

   task automatic settle();
      repeat (3) @(negedge clock);
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [7:0] stream1 [7];
      stream1 = '{8'h00, 8'h02, 8'hC0, 8'hFF, 8'h31, 8'h02, 8'hF4};

      reset_n  = 1'b0;
      start    = 1'b0;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      #12;
      check("rst_busy",  32'(busy),  32'd0);
      check("rst_ready", 32'(rx_ready), 32'd0);
      check("rst_done",  32'(done),  32'd0);
      check("rst_error", 32'(error), 32'd0);
      @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);

      $display("[TB] two-word load");
      expect_write(8'h00, 16'hC0FF);
      expect_write(8'h01, 16'h3102);
      pulse_start();
      check("t1_busy_started", 32'(busy), 32'd1);
      foreach (stream1[i]) send_byte(stream1[i], 0);
      check("t1_done",  32'(done),  32'd1);
      check("t1_error", 32'(error), 32'd0);
      check("t1_busy",  32'(busy),  32'd0);
      check("t1_words", 32'(words_loaded), 32'd2);
      check("t1_queue", exp_q.size(), 32'd0);
      settle();
      check("t1_done_sticky", 32'(done), 32'd1);

      $display("[TB] zero length");
      pulse_start();
      check("t2_done_cleared", 32'(done), 32'd0);
      send_byte(8'h00, 0);
      send_byte(8'h00, 0);
      check("t2_error", 32'(error), 32'd1);
      check("t2_busy",  32'(busy),  32'd0);
      check("t2_words", 32'(words_loaded), 32'd0);
      settle();

      $display("[TB] length 257");
      pulse_start();
      send_byte(8'h01, 0);
      send_byte(8'h01, 0);
      check("t3_error", 32'(error), 32'd1);
      check("t3_done",  32'(done),  32'd0);
      settle();

      $display("[TB] 256 words with gaps");
      for (int i = 0; i < 256; i++) expect_write(8'(i), {8'(i), ~8'(i)});
      pulse_start();
      send_byte(8'h01, 1);
      send_byte(8'h00, 0);
      for (int i = 0; i < 256; i++) begin
         send_byte(8'(i), int'($urandom_range(0, 2)));
         send_byte(~8'(i), int'($urandom_range(0, 2)));
      end
      // 01 + 00 + 256 * (hi + ~hi = FF) is 0x01 modulo 256
      send_byte(8'h01, 1);
      check("t4_done",  32'(done),  32'd1);
      check("t4_error", 32'(error), 32'd0);
      check("t4_words", 32'(words_loaded), 32'd256);
      check("t4_queue", exp_q.size(), 32'd0);
      settle();

      $display("[TB] bad checksum");
      expect_write(8'h00, 16'hC0FF);
      expect_write(8'h01, 16'h3102);
      pulse_start();
      for (int i = 0; i < 6; i++) send_byte(stream1[i], 0);
      send_byte(8'hF5, 0);
      check("t5_error", 32'(error), 32'd1);
      check("t5_done",  32'(done),  32'd0);
      check("t5_words", 32'(words_loaded), 32'd2);
      check("t5_queue", exp_q.size(), 32'd0);
      settle();

      $display("[TB] reset mid-load");
      expect_write(8'h00, 16'h1111);
      expect_write(8'h01, 16'h2222);
      expect_write(8'h02, 16'h3333);
      pulse_start();
      send_byte(8'h00, 0);
      send_byte(8'h05, 0);
      send_byte(8'h11, 0); send_byte(8'h11, 0);
      send_byte(8'h22, 0); send_byte(8'h22, 0);
      send_byte(8'h33, 0); send_byte(8'h33, 0);
      #2;
      reset_n = 1'b0;
      #1;
      check("t6_wr_en",   32'(wr_en),   32'd0);
      check("t6_ready",   32'(rx_ready), 32'd0);
      check("t6_addr",    32'(wr_addr), 32'd0);
      check("t6_data",    32'(wr_data), 32'd0);
      check("t6_busy",    32'(busy),    32'd0);
      check("t6_done",    32'(done),    32'd0);
      check("t6_error",   32'(error),   32'd0);
      check("t6_words",   32'(words_loaded), 32'd0);
      check("t6_queue",   exp_q.size(), 32'd0);
      @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
      expect_write(8'h00, 16'hABCD);
      pulse_start();
      send_byte(8'h00, 0);
      send_byte(8'h01, 0);
      send_byte(8'hAB, 0);
      send_byte(8'hCD, 0);
      send_byte(8'h79, 0);
      check("t7_done",  32'(done),  32'd1);
      check("t7_words", 32'(words_loaded), 32'd1);
      check("t7_queue", exp_q.size(), 32'd0);
      settle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
